// File: rtl/maze_pkg.sv
// Shared types and heading constants for the maze solver and its path buffer.
package maze_pkg;

  localparam int unsigned HDNG_BASE_W = 12;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_W = 2'd1,
    DIR_S = 2'd2,
    DIR_E = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    TURN_L    = 2'd0,
    TURN_R    = 2'd1,
    TURN_U    = 2'd2,
    TURN_NONE = 2'd3
  } turn_e;

  typedef enum logic [1:0] {
    MODE_LEFT   = 2'd0,
    MODE_RIGHT  = 2'd1,
    MODE_REPLAY = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_STRT_MV   = 3'd1,
    ST_WAIT_MV   = 3'd2,
    ST_DECIDE    = 3'd3,
    ST_STRT_HDNG = 3'd4,
    ST_WAIT_HDNG = 3'd5,
    ST_DONE      = 3'd6
  } state_e;

  localparam logic [HDNG_BASE_W-1:0] HDNG_N = 12'h000;
  localparam logic [HDNG_BASE_W-1:0] HDNG_W = 12'h3FF;
  localparam logic [HDNG_BASE_W-1:0] HDNG_S = 12'h7FF;
  localparam logic [HDNG_BASE_W-1:0] HDNG_E = 12'hC00;

  function automatic logic [HDNG_BASE_W-1:0] hdng_of(input dir_e d);
    case (d)
      DIR_N:   return HDNG_N;
      DIR_W:   return HDNG_W;
      DIR_S:   return HDNG_S;
      default: return HDNG_E;
    endcase
  endfunction

  // Direction index step: left +1, right -1 (== +3 mod 4), U-turn +2.
  function automatic logic [1:0] turn_delta(input turn_e t);
    case (t)
      TURN_L:  return 2'd1;
      TURN_R:  return 2'd3;
      TURN_U:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/maze_path_buf.sv
// Turn-code path buffer: DEPTH x 2-bit, sequential write and read with a next-cycle read peek.
module maze_path_buf #(
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_wr,
  input  logic                     clr_rd,
  input  logic                     wr_en,
  input  logic [1:0]               wr_code,
  input  logic                     rd_en,
  output logic [1:0]               rd_code,
  output logic [1:0]               peek_code,
  output logic                     peek_avail,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_nxt;
  logic [AW:0]   rd_ptr_q, rd_ptr_nxt;
  logic [AW:0]   count_q, count_nxt;
  logic          wr_ok;

  // Pointer/count next values; the peek shows the code the read pointer lands on next cycle.
  always_comb begin
    count_nxt  = count_q;
    wr_ptr_nxt = wr_ptr_q;
    rd_ptr_nxt = rd_ptr_q;
    full       = (count_q == (AW+1)'(DEPTH));
    empty      = (rd_ptr_q >= count_q);
    wr_ok      = wr_en && !full && !clr_wr;
    if (clr_wr) begin
      count_nxt  = '0;
      wr_ptr_nxt = '0;
    end else if (wr_ok) begin
      count_nxt  = count_q + (AW+1)'(1);
      wr_ptr_nxt = wr_ptr_q + AW'(1);
    end
    if (clr_rd) begin
      rd_ptr_nxt = '0;
    end else if (rd_en && !empty) begin
      rd_ptr_nxt = rd_ptr_q + (AW+1)'(1);
    end
    peek_avail = (rd_ptr_nxt < count_nxt);
    rd_code    = mem[rd_ptr_q[AW-1:0]];
    peek_code  = mem[rd_ptr_nxt[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_nxt;
      rd_ptr_q <= rd_ptr_nxt;
      count_q  <= count_nxt;
    end
  end

  // Storage carries no reset; contents are only read below the recorded count.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_q] <= wr_code;
  end

  assign count = count_q;

endmodule

// File: rtl/maze_solve_gen.sv
// Maze solve sequencer: left/right-affinity wall following with turn recording and path replay.
module maze_solve_gen
  import maze_pkg::*;
#(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned HDNG_W = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_md,
  input  logic [1:0]               mode,
  input  logic                     lft_opn,
  input  logic                     rght_opn,
  input  logic                     frwrd_opn,
  input  logic                     mv_cmplt,
  input  logic                     sol_cmplt,
  output logic signed [HDNG_W-1:0] dsrd_hdng,
  output logic                     strt_hdng,
  output logic                     strt_mv,
  output logic                     stp_lft,
  output logic                     stp_rght,
  output logic [$clog2(DEPTH):0]   path_len,
  output logic                     path_ovfl
);

  state_e state_q, state_nxt;
  dir_e   dir_q, dir_nxt;
  mode_e  mode_q, mode_nxt, mode_in;
  turn_e  turn;
  logic   cmd_md_q, ovfl_q, ovfl_nxt;
  logic   start, clr_wr, clr_rd, decide_fire, replay_ok, record;
  logic   wr_en, rd_en, stp_lft_nxt, stp_rght_nxt;
  logic   buf_full, buf_empty, peek_avail;
  logic [1:0] rd_code, peek_code;
  logic signed [HDNG_BASE_W-1:0] hdng_nxt;

  maze_path_buf #(.DEPTH(DEPTH)) u_path_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_wr     (clr_wr),
    .clr_rd     (clr_rd),
    .wr_en      (wr_en),
    .wr_code    (turn),
    .rd_en      (rd_en),
    .rd_code    (rd_code),
    .peek_code  (peek_code),
    .peek_avail (peek_avail),
    .count      (path_len),
    .full       (buf_full),
    .empty      (buf_empty)
  );

  // Next-state logic; abort and solution found override the normal sequence.
  always_comb begin
    state_nxt   = state_q;
    mode_in     = mode_e'(mode);
    start       = (state_q == ST_IDLE) && cmd_md_q && !cmd_md;
    mode_nxt    = start ? mode_in : mode_q;
    clr_wr      = start && (mode_in != MODE_REPLAY);
    clr_rd      = start && (mode_in == MODE_REPLAY);
    case (state_q)
      ST_IDLE:      if (start) state_nxt = ST_STRT_MV;
      ST_STRT_MV:   state_nxt = ST_WAIT_MV;
      ST_WAIT_MV:   if (mv_cmplt) state_nxt = ST_DECIDE;
      ST_DECIDE:    state_nxt = ST_STRT_HDNG;
      ST_STRT_HDNG: state_nxt = ST_WAIT_HDNG;
      ST_WAIT_HDNG: if (mv_cmplt) state_nxt = ST_STRT_MV;
      ST_DONE:      state_nxt = ST_DONE;
      default:      state_nxt = ST_IDLE;
    endcase
    if (state_q != ST_IDLE) begin
      if (cmd_md) state_nxt = ST_IDLE;
      else if (sol_cmplt) state_nxt = ST_DONE;
    end
    decide_fire = (state_q == ST_DECIDE) && (state_nxt == ST_STRT_HDNG);
  end

  // Turn decision, recording, heading update and move-stop qualifiers.
  always_comb begin
    turn      = TURN_U;
    replay_ok = (mode_q == MODE_REPLAY) && !ovfl_q && !buf_empty;
    record    = (mode_q != MODE_REPLAY);
    if (replay_ok) begin
      turn = turn_e'(rd_code);
    end else if (mode_q == MODE_RIGHT) begin
      if (rght_opn)     turn = TURN_R;
      else if (lft_opn) turn = TURN_L;
    end else begin
      if (lft_opn)       turn = TURN_L;
      else if (rght_opn) turn = TURN_R;
    end
    wr_en    = decide_fire && record;
    rd_en    = decide_fire && replay_ok;
    dir_nxt  = decide_fire ? dir_e'(dir_q + turn_delta(turn)) : dir_q;
    hdng_nxt = signed'(hdng_of(dir_nxt));
    ovfl_nxt = ovfl_q;
    if (clr_wr)                ovfl_nxt = 1'b0;
    else if (wr_en && buf_full) ovfl_nxt = 1'b1;
    stp_lft_nxt  = 1'b0;
    stp_rght_nxt = 1'b0;
    if (state_nxt != ST_IDLE) begin
      case (mode_nxt)
        MODE_RIGHT: stp_rght_nxt = 1'b1;
        MODE_REPLAY: begin
          if (!ovfl_nxt && peek_avail) begin
            stp_lft_nxt  = (turn_e'(peek_code) == TURN_L);
            stp_rght_nxt = (turn_e'(peek_code) == TURN_R);
          end else begin
            stp_lft_nxt  = 1'b1;
          end
        end
        default:    stp_lft_nxt = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      dir_q     <= DIR_N;
      mode_q    <= MODE_LEFT;
      cmd_md_q  <= 1'b0;
      ovfl_q    <= 1'b0;
      dsrd_hdng <= '0;
      strt_mv   <= 1'b0;
      strt_hdng <= 1'b0;
      stp_lft   <= 1'b0;
      stp_rght  <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      dir_q     <= dir_nxt;
      mode_q    <= mode_nxt;
      cmd_md_q  <= cmd_md;
      ovfl_q    <= ovfl_nxt;
      dsrd_hdng <= HDNG_W'(hdng_nxt);
      strt_mv   <= (state_nxt == ST_STRT_MV);
      strt_hdng <= (state_nxt == ST_STRT_HDNG);
      stp_lft   <= stp_lft_nxt;
      stp_rght  <= stp_rght_nxt;
    end
  end

  assign path_ovfl = ovfl_q;

endmodule

// File: tb/tb_maze_solve_gen.sv
// Directed bench for maze_solve_gen: default-depth instance plus a DEPTH=4 instance on shared stimulus.
module tb_maze_solve_gen;

  logic        clk = 1'b0;
  logic        rst_n, cmd_md, lft_opn, rght_opn, frwrd_opn, mv_cmplt, sol_cmplt;
  logic [1:0]  mode;
  logic [11:0] dsrd_hdng, dsrd_hdng4;
  logic        strt_hdng, strt_mv, stp_lft, stp_rght, path_ovfl;
  logic        strt_hdng4, strt_mv4, stp_lft4, stp_rght4, path_ovfl4;
  logic [6:0]  path_len;
  logic [2:0]  path_len4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  maze_solve_gen dut (
    .clk(clk), .rst_n(rst_n), .cmd_md(cmd_md), .mode(mode),
    .lft_opn(lft_opn), .rght_opn(rght_opn), .frwrd_opn(frwrd_opn),
    .mv_cmplt(mv_cmplt), .sol_cmplt(sol_cmplt), .dsrd_hdng(dsrd_hdng),
    .strt_hdng(strt_hdng), .strt_mv(strt_mv), .stp_lft(stp_lft),
    .stp_rght(stp_rght), .path_len(path_len), .path_ovfl(path_ovfl)
  );

  maze_solve_gen #(.DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .cmd_md(cmd_md), .mode(mode),
    .lft_opn(lft_opn), .rght_opn(rght_opn), .frwrd_opn(frwrd_opn),
    .mv_cmplt(mv_cmplt), .sol_cmplt(sol_cmplt), .dsrd_hdng(dsrd_hdng4),
    .strt_hdng(strt_hdng4), .strt_mv(strt_mv4), .stp_lft(stp_lft4),
    .stp_rght(stp_rght4), .path_len(path_len4), .path_ovfl(path_ovfl4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_hdng(input string tag, input logic [11:0] exp);
    chk({tag, "_pulse"}, 32'(strt_hdng), 32'd1);
    chk({tag, "_hdng"}, 32'(dsrd_hdng), 32'(exp));
  endtask

  // Idle -> WAIT_MV; mode is scrambled after the fall to show it is not re-sampled.
  task automatic start_solve(input logic [1:0] m);
    mode   = m;
    cmd_md = 1'b0;
    step();
    chk("strt_mv_pulse", 32'(strt_mv), 32'd1);
    mode = m ^ 2'd1;
    step();
    chk("strt_mv_single", 32'(strt_mv), 32'd0);
  endtask

  // WAIT_MV -> DECIDE -> STRT_HDNG with the given openings.
  task automatic turn(input logic l, input logic r, input logic f);
    lft_opn   = l;
    rght_opn  = r;
    frwrd_opn = f;
    mv_cmplt  = 1'b1;
    step();
    mv_cmplt = 1'b0;
    chk("no_hdng_in_decide", 32'(strt_hdng), 32'd0);
    step();
  endtask

  // STRT_HDNG -> WAIT_HDNG -> STRT_MV -> WAIT_MV.
  task automatic resume();
    step();
    chk("strt_hdng_single", 32'(strt_hdng), 32'd0);
    mv_cmplt = 1'b1;
    step();
    mv_cmplt = 1'b0;
    chk("strt_mv_after_hdng", 32'(strt_mv), 32'd1);
    step();
  endtask

  task automatic abort_solve();
    cmd_md = 1'b1;
    step();
    chk("abort_stp_lft", 32'(stp_lft), 32'd0);
    chk("abort_stp_rght", 32'(stp_rght), 32'd0);
  endtask

  initial begin
    logic [11:0] ovf_hdng [6];
    ovf_hdng = '{12'h3FF, 12'h7FF, 12'hC00, 12'h000, 12'h3FF, 12'h7FF};
    rst_n = 1'b0; cmd_md = 1'b1; mode = 2'd0;
    lft_opn = 1'b0; rght_opn = 1'b0; frwrd_opn = 1'b0;
    mv_cmplt = 1'b0; sol_cmplt = 1'b0;
    #12;
    chk("rst_strt_mv", 32'(strt_mv), 32'd0);
    chk("rst_strt_hdng", 32'(strt_hdng), 32'd0);
    chk("rst_hdng", 32'(dsrd_hdng), 32'h000);
    chk("rst_stp", 32'({stp_lft, stp_rght}), 32'd0);
    chk("rst_len", 32'(path_len), 32'd0);
    chk("rst_ovfl", 32'(path_ovfl), 32'd0);
    rst_n = 1'b1;
    step();
    step();

    // Mode 0, left open on the first decision: west.
    start_solve(2'd0);
    chk("m0_stp", 32'({stp_lft, stp_rght}), 32'b10);
    turn(1'b1, 1'b0, 1'b0);
    chk_hdng("m0_left", 12'h3FF);
    chk("m0_len1", 32'(path_len), 32'd1);
    resume();
    abort_solve();
    chk("abort_keeps_len", 32'(path_len), 32'd1);

    // Mode 1: west -> U -> east -> U -> west -> R -> north.
    start_solve(2'd1);
    chk("m1_clears_len", 32'(path_len), 32'd0);
    chk("m1_stp", 32'({stp_lft, stp_rght}), 32'b01);
    turn(1'b0, 1'b0, 1'b0);
    chk_hdng("m1_to_east", 12'hC00);
    resume();
    turn(1'b0, 1'b0, 1'b0);
    chk_hdng("m1_uturn_from_east", 12'h3FF);
    resume();
    turn(1'b1, 1'b1, 1'b0);
    chk_hdng("m1_right_from_west", 12'h000);
    chk("m1_len3", 32'(path_len), 32'd3);
    resume();

    // Solution and move complete together in WAIT_MV: DONE, no heading start.
    sol_cmplt = 1'b1;
    mv_cmplt  = 1'b1;
    step();
    sol_cmplt = 1'b0;
    chk("sol_no_hdng", 32'(strt_hdng), 32'd0);
    chk("sol_hdng_held", 32'(dsrd_hdng), 32'h000);
    step();
    step();
    mv_cmplt = 1'b0;
    chk("done_no_hdng", 32'(strt_hdng), 32'd0);
    chk("done_no_mv", 32'(strt_mv), 32'd0);
    chk("done_stp_held", 32'({stp_lft, stp_rght}), 32'b01);
    chk("done_len_held", 32'(path_len), 32'd3);
    abort_solve();

    // Set up heading south, then record L,R,U from south.
    start_solve(2'd0);
    turn(1'b0, 1'b0, 1'b0);
    chk_hdng("setup_south", 12'h7FF);
    resume();
    abort_solve();
    start_solve(2'd0);
    turn(1'b1, 1'b0, 1'b0);
    chk_hdng("rec_l", 12'hC00);
    resume();
    turn(1'b0, 1'b1, 1'b0);
    chk_hdng("rec_r", 12'h7FF);
    resume();
    turn(1'b0, 1'b0, 1'b0);
    chk_hdng("rec_u", 12'h000);
    chk("rec_len3", 32'(path_len), 32'd3);
    resume();
    abort_solve();

    // Replay L,R,U with blind sensors, then fall back to left affinity.
    start_solve(2'd2);
    chk("rp_len_kept", 32'(path_len), 32'd3);
    chk("rp_stp_l", 32'({stp_lft, stp_rght}), 32'b10);
    turn(1'b0, 1'b0, 1'b0);
    chk_hdng("rp_l", 12'h3FF);
    chk("rp_stp_r", 32'({stp_lft, stp_rght}), 32'b01);
    resume();
    turn(1'b0, 1'b0, 1'b0);
    chk_hdng("rp_r", 12'h000);
    chk("rp_stp_u", 32'({stp_lft, stp_rght}), 32'b00);
    resume();
    turn(1'b0, 1'b0, 1'b0);
    chk_hdng("rp_u", 12'h7FF);
    chk("rp_stp_exhausted", 32'({stp_lft, stp_rght}), 32'b10);
    resume();
    turn(1'b0, 1'b0, 1'b0);
    chk_hdng("rp_exhausted_uturn", 12'h000);
    chk("rp_no_record", 32'(path_len), 32'd3);
    resume();
    abort_solve();

    // Six left decisions: DEPTH=4 instance saturates and flags overflow on the fifth.
    start_solve(2'd0);
    for (int i = 1; i <= 6; i++) begin
      turn(1'b1, 1'b0, 1'b0);
      chk_hdng("ovf_turn", ovf_hdng[i-1]);
      chk("ovf_len64", 32'(path_len), 32'(i));
      chk("ovf_len4", 32'(path_len4), (i > 4) ? 32'd4 : 32'(i));
      chk("ovf_flag4", 32'(path_ovfl4), (i > 4) ? 32'd1 : 32'd0);
      resume();
    end
    chk("ovf_flag64", 32'(path_ovfl), 32'd0);
    abort_solve();

    // Replay after overflow behaves as mode 0 on the small instance only.
    start_solve(2'd2);
    chk("rp_ovf_stp4", 32'({stp_lft4, stp_rght4}), 32'b10);
    turn(1'b0, 1'b1, 1'b0);
    chk_hdng("rp64_replays_l", 12'hC00);
    chk("rp4_follows_right", 32'(dsrd_hdng4), 32'h3FF);
    chk("rp4_no_record", 32'(path_len4), 32'd4);
    step();
    chk("wait_hdng_reached", 32'(strt_hdng), 32'd0);

    // Asynchronous reset while waiting on the heading.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_hdng", 32'(dsrd_hdng), 32'h000);
    chk("arst_len", 32'(path_len), 32'd0);
    chk("arst_stp", 32'({stp_lft, stp_rght}), 32'd0);
    chk("arst_pulses", 32'({strt_mv, strt_hdng}), 32'd0);
    chk("arst4_hdng", 32'(dsrd_hdng4), 32'h000);
    chk("arst4_len_ovfl", 32'({path_len4, path_ovfl4}), 32'd0);
    #2 rst_n = 1'b1;
    mv_cmplt = 1'b1;
    step();
    step();
    mv_cmplt = 1'b0;
    chk("post_rst_no_mv", 32'(strt_mv), 32'd0);
    chk("post_rst_no_hdng", 32'(strt_hdng), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/maze_solve_gen.md
MAZE_SOLVE_GEN -- requirements
Module: maze_solve_gen

Interface
REQ-001 SHALL have parameter DEPTH, default 64, path-buffer entries (power of 2, 4..256).
REQ-002 SHALL have parameter HDNG_W, default 12, heading width.
REQ-003 SHALL have ports: clk  input  1  system clock.
REQ-004 SHALL have ports: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: cmd_md  input  1  high = command mode, solver idle.
REQ-006 SHALL have ports: mode  input  2  solve mode; 0 left-affinity, 1 right-affinity, 2 replay, 3 reserved (acts as 0).
REQ-007 SHALL have ports: lft_opn, rght_opn, frwrd_opn  input  1 each  maze openings.
REQ-008 SHALL have ports: mv_cmplt  input  1  navigate finished heading or move.
REQ-009 SHALL have ports: sol_cmplt  input  1  magnet found.
REQ-010 SHALL have ports: dsrd_hdng  output  HDNG_W signed  desired heading.
REQ-011 SHALL have ports: strt_hdng, strt_mv  output  1 each  single-cycle start pulses.
REQ-012 SHALL have ports: stp_lft, stp_rght  output  1 each  move-stop qualifiers.
REQ-013 SHALL have ports: path_len  output  $clog2(DEPTH)+1  recorded turn count.
REQ-014 SHALL have ports: path_ovfl  output  1  sticky: a turn was dropped for lack of space.

Function
REQ-015 SHALL sample mode on the cycle cmd_md falls; later changes to mode are ignored until the next fall.
REQ-016 SHALL run states IDLE, STRT_MV, WAIT_MV, DECIDE, STRT_HDNG, WAIT_HDNG, DONE.
REQ-017 SHALL go IDLE->STRT_MV one cycle after cmd_md falls; in STRT_MV it pulses strt_mv for one cycle, then goes to WAIT_MV.
REQ-018 SHALL go WAIT_MV->DECIDE on mv_cmplt, and DECIDE->STRT_HDNG after one cycle; in STRT_HDNG it pulses strt_hdng for one cycle, then goes to WAIT_HDNG.
REQ-019 SHALL go WAIT_HDNG->STRT_MV on mv_cmplt; mv_cmplt is ignored in all other states.
REQ-020 SHALL keep a 2-bit direction index: 0 north 12'h000, 1 west 12'h3FF, 2 south 12'h7FF, 3 east 12'hC00; dsrd_hdng is the decoded index (sign-extended to HDNG_W).
REQ-021 SHALL update the index mod 4 in DECIDE: left +1, right -1, U-turn +2 (3+1 wraps to 0).
REQ-022 SHALL decide turns in mode 0 as: left if lft_opn, else right if rght_opn, else U-turn.
REQ-023 SHALL decide turns in mode 1 as: right if rght_opn, else left if lft_opn, else U-turn.
REQ-024 SHALL drive stp_lft=1/stp_rght=0 in mode 0 and stp_lft=0/stp_rght=1 in mode 1, throughout the solve.
REQ-025 SHALL record each mode 0/1 decision as a turn code (L, R, U) at the write pointer and increment path_len.
REQ-026 SHALL, when the buffer is full, drop the code, hold path_len at DEPTH, and set path_ovfl.
REQ-027 SHALL replay in mode 2: read codes sequentially, ignore sensors, and set stp_lft/stp_rght from the next code (L: 1/0, R: 0/1, U: 0/0).
REQ-028 SHALL treat mode 2 as mode 0, with no recording, when path_len==0, path_ovfl==1, or the codes are exhausted.
REQ-029 SHALL clear path_len, the write pointer and path_ovfl on each mode 0/1 start; mode 2 resets only the read pointer.
REQ-030 SHALL, on sol_cmplt in any non-IDLE state, go to DONE next cycle; no further pulses are issued and DONE is held until cmd_md is high.
REQ-031 SHALL abort to IDLE next cycle if cmd_md rises mid-solve; buffer contents and path_len are retained.
REQ-032 SHALL give sol_cmplt priority when sol_cmplt and mv_cmplt occur in the same cycle.

Reset
REQ-033 SHALL, on rst_n low, asynchronously force state=IDLE, index=0, dsrd_hdng=12'h000, strt_hdng=strt_mv=0, stp_lft=stp_rght=0, path_len=0, path_ovfl=0, and both pointers to 0.
REQ-034 SHALL make buffer contents don't-care after reset; reset mid-solve leaves no pending pulse.

Structure
REQ-035 SHALL place the direction enum, turn-code enum, mode enum and the four heading constants in shared package maze_pkg.
REQ-036 SHALL implement the path buffer as sub-module maze_path_buf: DEPTH x 2-bit, write/read pointers, full/empty flags, synchronous write.

Verification
REQ-037 SHALL cover: mode 0, lft_opn=1 at the first mv_cmplt -> strt_hdng pulse with dsrd_hdng=12'h3FF, path_len=1.
REQ-038 SHALL cover: mode 1 from east (index 3), lft=rght=0 -> U-turn, dsrd_hdng=12'h3FF; then from west, rght_opn -> dsrd_hdng=12'h000.
REQ-039 SHALL cover: DEPTH=4, six mode-0 decisions -> path_len=4 and path_ovfl=1 after the fifth.
REQ-040 SHALL cover: record L,R,U in mode 0, then mode 2 with all sensors 0 -> headings 12'h3FF, 12'h000, 12'h7FF.
REQ-041 SHALL cover: sol_cmplt and mv_cmplt in the same cycle in WAIT_MV -> DONE, no strt_hdng.
REQ-042 SHALL cover: rst_n low during WAIT_HDNG -> all outputs at reset values within the same cycle.
